// File: rtl/rgmii_rx_frame_ctrl.sv
// Frame-level sequencer behind rgmii_rx: tracks the Ethernet header, filters by EtherType and
// forwards payload bytes. Define RX_MAC_FILTER_EN to also filter on destination MAC.
module rgmii_rx_frame_ctrl #(
  parameter logic [15:0] ETHERTYPE       = 16'h0800,
  parameter int unsigned MAX_FRAME_BYTES = 1518,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             rxClk,
  input  logic             rstRxLcl,
  input  logic             enIn,
  input  logic [47:0]      macAddrIn,
  input  logic [7:0]       rxDataIn,
  input  logic             rxDataValidIn,
  input  logic             rxDataLastIn,
  output logic [7:0]       pldDataOut,
  output logic             pldValidOut,
  output logic             pldLastOut,
  output logic             pldErrOut,
  output logic [15:0]      etherTypeOut,
  output logic             etherTypeValidOut,
  output logic [CNT_W-1:0] frameCntOut,
  output logic [CNT_W-1:0] dropCntOut,
  output logic             busyOut
);

  localparam int unsigned BCW = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [BCW-1:0] LastIdx = BCW'(MAX_FRAME_BYTES - 1);

  localparam logic [2:0] StSync    = 3'd0;
  localparam logic [2:0] StIdle    = 3'd1;
  localparam logic [2:0] StHdr     = 3'd2;
  localparam logic [2:0] StPayload = 3'd3;
  localparam logic [2:0] StDrop    = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]     etype_hi_q, etype_hi_d;
  logic           frame_inc, drop_inc, etype_load;
  logic           pld_valid_d, pld_last_d, pld_err_d;
  logic           mac_ok;

`ifdef RX_MAC_FILTER_EN
  logic [47:0] mac_q;
  logic        uc_match_q, bc_match_q;
  logic [7:0]  mac_byte;

  always_comb begin
    mac_byte = 8'h00;
    for (int i = 1; i < 6; i++) begin
      if (byte_cnt_q == BCW'(i)) mac_byte = mac_q[47-8*i -: 8];
    end
  end

  // Station address is latched at frame start so mid-frame changes cannot affect the verdict.
  always_ff @(posedge rxClk or negedge rstRxLcl) begin
    if (!rstRxLcl) begin
      mac_q      <= '0;
      uc_match_q <= 1'b0;
      bc_match_q <= 1'b0;
    end else if (rxDataValidIn && state_q == StIdle) begin
      mac_q      <= macAddrIn;
      uc_match_q <= (rxDataIn == macAddrIn[47:40]);
      bc_match_q <= (rxDataIn == 8'hFF);
    end else if (rxDataValidIn && state_q == StHdr && byte_cnt_q < BCW'(6)) begin
      uc_match_q <= uc_match_q & (rxDataIn == mac_byte);
      bc_match_q <= bc_match_q & (rxDataIn == 8'hFF);
    end
  end

  assign mac_ok = uc_match_q | bc_match_q;
`else
  logic unused_mac;
  assign unused_mac = ^macAddrIn;
  assign mac_ok     = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    etype_hi_d  = etype_hi_q;
    frame_inc   = 1'b0;
    drop_inc    = 1'b0;
    etype_load  = 1'b0;
    pld_valid_d = 1'b0;
    pld_last_d  = 1'b0;
    pld_err_d   = 1'b0;
    case (state_q)
      StSync: begin
        if (!rxDataValidIn) state_d = StIdle;
      end
      StIdle: begin
        if (rxDataValidIn) begin
          byte_cnt_d = BCW'(1);
          if (rxDataLastIn) begin
            drop_inc = 1'b1;
            state_d  = StSync;
          end else if (!enIn) begin
            drop_inc = 1'b1;
            state_d  = StDrop;
          end else begin
            state_d = StHdr;
          end
        end
      end
      StHdr: begin
        if (rxDataValidIn) begin
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == BCW'(12)) etype_hi_d = rxDataIn;
          if (rxDataLastIn) begin
            drop_inc = 1'b1;
            state_d  = StSync;
          end else if (byte_cnt_q == BCW'(13)) begin
            if ({etype_hi_q, rxDataIn} == ETHERTYPE && mac_ok) begin
              etype_load = 1'b1;
              state_d    = StPayload;
            end else begin
              drop_inc = 1'b1;
              state_d  = StDrop;
            end
          end
        end
      end
      StPayload: begin
        if (rxDataValidIn) begin
          pld_valid_d = 1'b1;
          byte_cnt_d  = byte_cnt_q + BCW'(1);
          if (rxDataLastIn) begin
            pld_last_d = 1'b1;
            frame_inc  = 1'b1;
            state_d    = StSync;
          end else if (byte_cnt_q == LastIdx) begin
            // Truncation is counted here, so the DROP entry below must not count again.
            pld_last_d = 1'b1;
            pld_err_d  = 1'b1;
            drop_inc   = 1'b1;
            state_d    = StDrop;
          end
        end
      end
      StDrop: begin
        if (rxDataValidIn && rxDataLastIn) state_d = StSync;
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge rxClk or negedge rstRxLcl) begin
    if (!rstRxLcl) begin
      state_q           <= StSync;
      byte_cnt_q        <= '0;
      etype_hi_q        <= '0;
      pldDataOut        <= '0;
      pldValidOut       <= 1'b0;
      pldLastOut        <= 1'b0;
      pldErrOut         <= 1'b0;
      etherTypeOut      <= '0;
      etherTypeValidOut <= 1'b0;
      frameCntOut       <= '0;
      dropCntOut        <= '0;
    end else begin
      state_q           <= state_d;
      byte_cnt_q        <= byte_cnt_d;
      etype_hi_q        <= etype_hi_d;
      pldValidOut       <= pld_valid_d;
      pldLastOut        <= pld_last_d;
      pldErrOut         <= pld_err_d;
      etherTypeValidOut <= etype_load;
      if (pld_valid_d) pldDataOut <= rxDataIn;
      if (etype_load) etherTypeOut <= {etype_hi_q, rxDataIn};
      if (frame_inc) frameCntOut <= frameCntOut + CNT_W'(1);
      if (drop_inc) dropCntOut <= dropCntOut + CNT_W'(1);
    end
  end

  assign busyOut = (state_q == StHdr) || (state_q == StPayload) || (state_q == StDrop);

endmodule

// File: tb/tb_rgmii_rx_frame_ctrl.sv
// Scoreboard bench for rgmii_rx_frame_ctrl: a frame-level model predicts payload bytes, EtherType
// pulses and counters; a monitor pops expectations whenever the DUT presents output.
module tb_rgmii_rx_frame_ctrl;
  localparam int MAX = 1518;
  localparam logic [47:0] STATION = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BCAST   = 48'hFF_FF_FF_FF_FF_FF;

  logic        rxClk = 1'b0;
  logic        rstRxLcl = 1'b0;
  logic        enIn = 1'b0;
  logic [47:0] macAddrIn = STATION;
  logic [7:0]  rxDataIn = 8'h00;
  logic        rxDataValidIn = 1'b0;
  logic        rxDataLastIn = 1'b0;
  logic [7:0]  pldDataOut;
  logic        pldValidOut, pldLastOut, pldErrOut;
  logic [15:0] etherTypeOut;
  logic        etherTypeValidOut;
  logic [31:0] frameCntOut, dropCntOut;
  logic        busyOut;

  rgmii_rx_frame_ctrl dut (
    .rxClk             (rxClk),
    .rstRxLcl          (rstRxLcl),
    .enIn              (enIn),
    .macAddrIn         (macAddrIn),
    .rxDataIn          (rxDataIn),
    .rxDataValidIn     (rxDataValidIn),
    .rxDataLastIn      (rxDataLastIn),
    .pldDataOut        (pldDataOut),
    .pldValidOut       (pldValidOut),
    .pldLastOut        (pldLastOut),
    .pldErrOut         (pldErrOut),
    .etherTypeOut      (etherTypeOut),
    .etherTypeValidOut (etherTypeValidOut),
    .frameCntOut       (frameCntOut),
    .dropCntOut        (dropCntOut),
    .busyOut           (busyOut)
  );

  always #5 rxClk = ~rxClk;

  int cyc = 0;
  always @(posedge rxClk) cyc++;

  typedef struct { int cyc; logic [7:0] d; logic last; logic err; } pld_t;
  typedef struct { int cyc; logic [15:0] et; } et_t;

  pld_t        pld_q[$];
  et_t         et_q[$];
  logic [7:0]  frm[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_frame = 0;
  int          exp_drop = 0;
  logic [15:0] exp_et = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got a valid output, expected none (cycle %0d)", name, cyc);
  endtask

  task automatic mon_pld();
    pld_t e;
    if (pld_q.size() == 0) flag_unexpected("pld_unexpected");
    else begin
      e = pld_q.pop_front();
      check("pld_byte_last_err", 64'({pldDataOut, pldLastOut, pldErrOut}),
            64'({e.d, e.last, e.err}));
      check("pld_cycle", 64'(cyc), 64'(e.cyc));
    end
  endtask

  task automatic mon_et();
    et_t e;
    if (et_q.size() == 0) flag_unexpected("ethertype_unexpected");
    else begin
      e = et_q.pop_front();
      check("ethertype_value", 64'(etherTypeOut), 64'(e.et));
      check("ethertype_cycle", 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge rxClk) begin
    if (rstRxLcl) begin
      if (pldValidOut) mon_pld();
      if (etherTypeValidOut) mon_et();
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic build(input int len, input logic [15:0] et, input logic [47:0] dst,
                       input logic inc);
    frm.delete();
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      if (i < 6) b = dst[47-8*i -: 8];
      else if (i == 12) b = et[15:8];
      else if (i == 13) b = et[7:0];
      else if (i >= 14 && inc) b = 8'(i - 14);
      else b = 8'($urandom);
      frm.push_back(b);
    end
  endtask

  task automatic pulse_reset();
    #2 rstRxLcl = 1'b0;
    #1;
    check("rst_pld_outputs", 64'({pldValidOut, pldLastOut, pldErrOut, pldDataOut}), 64'(0));
    check("rst_ethertype", 64'({etherTypeValidOut, etherTypeOut}), 64'(0));
    check("rst_frame_cnt", 64'(frameCntOut), 64'(0));
    check("rst_drop_cnt", 64'(dropCntOut), 64'(0));
    check("rst_busy", 64'(busyOut), 64'(0));
    exp_frame = 0;
    exp_drop  = 0;
    exp_et    = 16'h0;
    @(negedge rxClk);
    #2 rstRxLcl = 1'b1;
  endtask

  // stall: 0 contiguous, 1 one idle cycle after every second byte, 2 random idle cycles
  task automatic send_frame(input logic en, input int stall, input int rst_at);
    int len;
    logic [15:0] et;
    logic [47:0] dst;
    logic mac_ok, accept, trunc;
    int hi;
    len = frm.size();
    et  = (len >= 14) ? {frm[12], frm[13]} : 16'h0;
    dst = '0;
    for (int i = 0; i < 6 && i < len; i++) dst[47-8*i -: 8] = frm[i];
    mac_ok = 1'b1;
`ifdef RX_MAC_FILTER_EN
    mac_ok = (dst == STATION) || (dst == BCAST);
`endif
    accept = en && (len >= 15) && (et == 16'h0800) && mac_ok;
    trunc  = accept && (len > MAX);
    hi     = !accept ? 14 : (trunc ? MAX : len);
    for (int i = 0; i < len; i++) begin
      int n;
      pld_t p;
      et_t t;
      n = 0;
      if (i > 0 && stall == 1) n = (i % 2 == 0) ? 1 : 0;
      if (i > 0 && stall == 2) n = int'($urandom_range(0, 2));
      repeat (n) begin
        @(negedge rxClk);
        rxDataValidIn = 1'b0;
        rxDataIn      = 8'($urandom);
        rxDataLastIn  = 1'($urandom);
      end
      @(negedge rxClk);
      enIn          = (i == 0) ? en : 1'($urandom);
      rxDataValidIn = 1'b1;
      rxDataIn      = frm[i];
      rxDataLastIn  = (i == len - 1);
      if (i == rst_at) pulse_reset();
      else if (i >= 14 && i < hi && (rst_at < 0 || i < rst_at)) begin
        p.cyc  = cyc + 1;
        p.d    = frm[i];
        p.last = (i == hi - 1);
        p.err  = trunc && (i == hi - 1);
        pld_q.push_back(p);
      end
      if (i == 13 && accept && (rst_at < 0 || rst_at > 13)) begin
        t.cyc = cyc + 1;
        t.et  = et;
        et_q.push_back(t);
      end
    end
    @(negedge rxClk);
    rxDataValidIn = 1'b0;
    rxDataLastIn  = 1'b0;
    if (rst_at < 0) begin
      if (accept && !trunc) exp_frame++;
      else exp_drop++;
      if (accept) exp_et = et;
    end
    repeat (3) @(negedge rxClk);
    check("frame_cnt", 64'(frameCntOut), 64'(exp_frame));
    check("drop_cnt", 64'(dropCntOut), 64'(exp_drop));
    check("ethertype_out", 64'(etherTypeOut), 64'(exp_et));
    check("busy_between_frames", 64'(busyOut), 64'(0));
  endtask

  task automatic run_random(input int count);
    for (int f = 0; f < count; f++) begin
      int len;
      logic [15:0] et;
      logic [47:0] dst;
      int pick;
      len  = int'($urandom_range(1, 120));
      pick = int'($urandom_range(0, 9));
      et   = (pick < 7) ? 16'h0800 : (pick == 7 ? 16'h0801 : 16'($urandom));
      pick = int'($urandom_range(0, 2));
      dst  = (pick == 0) ? STATION : (pick == 1 ? BCAST : {16'h0200, 32'($urandom)});
      build(len, et, dst, 1'b0);
      send_frame(($urandom_range(0, 9) != 0), int'($urandom_range(0, 2)), -1);
    end
  endtask

  initial begin
    repeat (3) @(negedge rxClk);
    check("reset_pld", 64'({pldValidOut, pldLastOut, pldErrOut, pldDataOut}), 64'(0));
    check("reset_ethertype", 64'({etherTypeValidOut, etherTypeOut}), 64'(0));
    check("reset_counters", 64'({frameCntOut, dropCntOut}), 64'(0));
    check("reset_busy", 64'(busyOut), 64'(0));
    rstRxLcl = 1'b1;
    repeat (2) @(negedge rxClk);

    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b1, 0, -1);
    build(64, 16'h86DD, STATION, 1'b0);   send_frame(1'b1, 0, -1);
    build(1600, 16'h0800, STATION, 1'b0); send_frame(1'b1, 0, -1);
    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b1, 0, -1);
    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b1, 1, -1);
    build(11, 16'h0800, STATION, 1'b0);   send_frame(1'b1, 0, -1);
    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b0, 0, -1);
    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b1, 0, 40);
    build(114, 16'h0800, STATION, 1'b1);  send_frame(1'b1, 0, -1);
    build(14, 16'h0800, STATION, 1'b0);   send_frame(1'b1, 0, -1);
    build(15, 16'h0800, STATION, 1'b0);   send_frame(1'b1, 2, -1);
    build(1, 16'h0800, STATION, 1'b0);    send_frame(1'b1, 0, -1);
    build(MAX, 16'h0800, STATION, 1'b0);  send_frame(1'b1, 0, -1);
    build(MAX + 1, 16'h0800, STATION, 1'b0); send_frame(1'b1, 0, -1);
`ifdef RX_MAC_FILTER_EN
    build(80, 16'h0800, 48'h02_00_00_00_00_01, 1'b1); send_frame(1'b1, 0, -1);
    build(80, 16'h0800, BCAST, 1'b1);                 send_frame(1'b1, 0, -1);
`endif
    run_random(30);

    repeat (5) @(negedge rxClk);
    check("pld_queue_drained", 64'(pld_q.size()), 64'(0));
    check("ethertype_queue_drained", 64'(et_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
